// File: rtl/tracer_seq_ctrl.sv
// Contour-tracer segment sequencer: per segment it loads the center, streams N contour
// reads, waits out the memory latency, loads the contour and stores the trace.
module tracer_seq_ctrl #(
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned SEG_W  = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             s_axi_aclk,
  input  logic             s_axi_areset,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] num_points,
  input  logic [SEG_W-1:0] num_segments,
  input  logic             trace_ready,
  output logic             busy,
  output logic             done,
  output logic             load_center,
  output logic             contour_rden,
  output logic             load_contour,
  output logic             store_trace,
  output logic [SEG_W-1:0] seg_idx,
  output logic [CNT_W-1:0] point_idx
);

  typedef enum logic [2:0] {
    StIdle,
    StLcenter,
    StRead,
    StRwait,
    StLcontour,
    StStore,
    StDone
  } state_t;

  localparam logic [2:0] LpWaitLast = (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;
  localparam state_t     LpPostRead = (RD_LAT > 0) ? StRwait : StLcontour;

  state_t           r_state;
  logic [CNT_W-1:0] r_n;
  logic [SEG_W-1:0] r_s;
  logic [SEG_W-1:0] r_seg;
  logic [CNT_W-1:0] r_pt;
  logic [2:0]       r_wait;

  logic [CNT_W-1:0] w_pt_last;
  logic [SEG_W-1:0] w_seg_last;

  assign w_pt_last  = r_n - CNT_W'(1);
  assign w_seg_last = r_s - SEG_W'(1);

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state <= StIdle;
      r_n     <= '0;
      r_s     <= '0;
      r_seg   <= '0;
      r_pt    <= '0;
      r_wait  <= '0;
    end else if (abort && (r_state != StIdle)) begin
      r_state <= StIdle;
      r_seg   <= '0;
      r_pt    <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // abort arriving with start keeps the sequencer idle
          if (start && !abort) begin
            r_n     <= num_points;
            r_s     <= num_segments;
            r_seg   <= '0;
            r_pt    <= '0;
            r_state <= (num_segments == '0) ? StDone : StLcenter;
          end
        end
        StLcenter: begin
          r_wait  <= LpWaitLast;
          r_state <= (r_n != '0) ? StRead : LpPostRead;
        end
        StRead: begin
          if (r_pt == w_pt_last) begin
            r_wait  <= LpWaitLast;
            r_state <= LpPostRead;
          end else begin
            r_pt <= r_pt + CNT_W'(1);
          end
        end
        StRwait: begin
          if (r_wait == 3'd0) r_state <= StLcontour;
          else                r_wait  <= r_wait - 3'd1;
        end
        StLcontour: r_state <= StStore;
        StStore: begin
          if (trace_ready) begin
            if (r_seg == w_seg_last) begin
              r_state <= StDone;
            end else begin
              r_seg   <= r_seg + SEG_W'(1);
              r_pt    <= '0;
              r_state <= StLcenter;
            end
          end
        end
        StDone: begin
          r_seg   <= '0;
          r_pt    <= '0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign busy         = (r_state != StIdle) && (r_state != StDone);
  assign done         = (r_state == StDone);
  assign load_center  = (r_state == StLcenter);
  assign contour_rden = (r_state == StRead);
  assign load_contour = (r_state == StLcontour);
  assign store_trace  = (r_state == StStore) && trace_ready;
  assign seg_idx      = r_seg;
  assign point_idx    = r_pt;

endmodule

// File: tb/tb_tracer_seq_ctrl.sv
// Scoreboard bench for tracer_seq_ctrl: a schedule generator queues per-cycle stimulus
// with the expected output vector, and a driver replays and compares them cycle by cycle.
module tb_tracer_seq_ctrl;

  localparam int unsigned RdLat = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [7:0] num_points;
  logic [7:0] num_segments;
  logic       trace_ready;
  logic       busy;
  logic       done;
  logic       load_center;
  logic       contour_rden;
  logic       load_contour;
  logic       store_trace;
  logic [7:0] seg_idx;
  logic [7:0] point_idx;

  always #5 clk = ~clk;

  tracer_seq_ctrl #(
    .CNT_W (8),
    .SEG_W (8),
    .RD_LAT(RdLat)
  ) u_dut (
    .s_axi_aclk  (clk),
    .s_axi_areset(rst),
    .start       (start),
    .abort       (abort),
    .num_points  (num_points),
    .num_segments(num_segments),
    .trace_ready (trace_ready),
    .busy        (busy),
    .done        (done),
    .load_center (load_center),
    .contour_rden(contour_rden),
    .load_contour(load_contour),
    .store_trace (store_trace),
    .seg_idx     (seg_idx),
    .point_idx   (point_idx)
  );

  typedef struct packed {
    logic       rst;
    logic       start;
    logic       abort;
    logic       tr;
    logic [7:0] np;
    logic [7:0] ns;
  } stim_t;

  stim_t       stim_q[$];
  logic [21:0] exp_q[$];
  string       tag_q[$];

  int    n_vec = 0;
  int    n_err = 0;
  string g_tag;
  int    g_n, g_s, g_cyc, g_cut, g_cutkind;
  bit    g_stop, g_noise;

  task automatic check_eq(input string tag, input logic [21:0] obs, input logic [21:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got {busy,done,lc,rden,lcon,st,seg,pt}=%b_%h_%h required %b_%h_%h",
               tag, $time, obs[21:16], obs[15:8], obs[7:0], exp[21:16], exp[15:8], exp[7:0]);
    end
  endtask

  function automatic logic [21:0] ev(input bit b, input bit d, input bit lc, input bit rd,
                                     input bit lcon, input bit st, input int seg, input int pt);
    return {b, d, lc, rd, lcon, st, 8'(seg), 8'(pt)};
  endfunction

  task automatic push(input stim_t s, input logic [21:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
    tag_q.push_back(g_tag);
  endtask

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{rst: 1'b0, start: 1'b0, abort: 1'b0, tr: 1'b1, np: 8'(g_n), ns: 8'(g_s)};
    return s;
  endfunction

  // One cycle of a run; an optional cut injects abort or reset at cycle g_cut.
  task automatic emit(input bit first, input bit tr, input logic [21:0] e);
    stim_t s;
    if (g_stop) return;
    s = '{rst: 1'b0, start: first, abort: 1'b0, tr: tr, np: 8'(g_n), ns: 8'(g_s)};
    if (g_noise && !first) begin
      s.start = 1'($urandom_range(0, 1));
      s.np    = 8'($urandom);
      s.ns    = 8'($urandom);
    end
    if (g_cyc == g_cut) begin
      g_stop = 1'b1;
      if (g_cutkind == 1) begin
        s.abort = 1'b1;
      end else begin
        s.rst   = 1'b1;
        s.start = 1'b1;
      end
    end
    push(s, e);
    g_cyc++;
    if (g_stop) begin
      if (g_cutkind == 2) begin
        s = idle_stim();
        s.rst   = 1'b1;
        s.start = 1'b1;
        push(s, '0);
      end
      push(idle_stim(), '0);
    end
  endtask

  task automatic gen_run(input int n, input int s, input int stall);
    int last;
    g_n    = n;
    g_s    = s;
    g_cyc  = 0;
    g_stop = 1'b0;
    last   = (n > 0) ? n - 1 : 0;
    emit(1'b1, 1'b1, '0);
    if (s == 0) begin
      emit(1'b0, 1'b1, ev(0, 1, 0, 0, 0, 0, 0, 0));
    end else begin
      for (int k = 0; k < s; k++) begin
        emit(1'b0, 1'b1, ev(1, 0, 1, 0, 0, 0, k, 0));
        for (int i = 0; i < n; i++) emit(1'b0, 1'b1, ev(1, 0, 0, 1, 0, 0, k, i));
        for (int w = 0; w < int'(RdLat); w++) emit(1'b0, 1'b1, ev(1, 0, 0, 0, 0, 0, k, last));
        emit(1'b0, 1'b1, ev(1, 0, 0, 0, 1, 0, k, last));
        for (int t = 0; t < stall; t++) emit(1'b0, 1'b0, ev(1, 0, 0, 0, 0, 0, k, last));
        emit(1'b0, 1'b1, ev(1, 0, 0, 0, 0, 1, k, last));
      end
      emit(1'b0, 1'b1, ev(0, 1, 0, 0, 0, 0, s - 1, last));
    end
    if (!g_stop) push(idle_stim(), '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  initial begin
    stim_t s;
    logic [21:0] e;
    string t;
    rst = 1'b1; start = 1'b0; abort = 1'b0; trace_ready = 1'b1;
    num_points = '0; num_segments = '0;
    g_cut = -1; g_cutkind = 0; g_noise = 1'b0; g_n = 0; g_s = 0;
    repeat (2) @(posedge clk);

    g_tag = "reset";
    s = idle_stim(); s.rst = 1'b1; s.start = 1'b1;
    push(s, '0);
    push(idle_stim(), '0);

    g_tag = "nominal";      gen_run(4, 2, 0);
    g_tag = "backpressure"; gen_run(2, 1, 5);
    g_tag = "zero_segs";    gen_run(5, 0, 0);
    g_tag = "zero_points";  gen_run(0, 1, 0);

    g_tag = "abort"; g_cutkind = 1; g_cut = 4;
    gen_run(8, 1, 0);
    g_cut = -1;
    g_tag = "after_abort";  gen_run(8, 1, 0);

    g_tag = "abort_start_idle";
    s = idle_stim(); s.start = 1'b1; s.abort = 1'b1;
    push(s, '0);
    push(idle_stim(), '0);

    g_tag = "reset_midrun"; g_cutkind = 2; g_cut = 7;
    gen_run(2, 1, 3);
    g_cut = -1;
    g_tag = "after_reset";  gen_run(2, 1, 0);

    g_tag = "ignored_inputs"; g_noise = 1'b1;
    gen_run(4, 2, 0);
    g_noise = 1'b0;

    g_tag = "max_segs";     gen_run(0, 255, 0);

    while (stim_q.size() > 0) begin
      @(negedge clk);
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      rst          = s.rst;
      start        = s.start;
      abort        = s.abort;
      trace_ready  = s.tr;
      num_points   = s.np;
      num_segments = s.ns;
      #1;
      check_eq(t, {busy, done, load_center, contour_rden, load_contour, store_trace,
                   seg_idx, point_idx}, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/tracer_seq_ctrl.md
Name: tracer_seq_ctrl

Overview:
- Sequencer for the contour-tracer segment stage. Generates the four per-segment strobes `load_center`, `contour_rden`, `load_contour` and `store_trace`.
- Sits directly upstream of the segment control stage, which consumes these strobes.
- Walks a programmed number of segments. For each segment it loads the center, streams N contour points, loads the contour, and stores the trace under a downstream ready handshake.

Parameters:
- CNT_W, 8, width of point counter and of num_points.
- SEG_W, 8, width of segment counter and of num_segments.
- RD_LAT, 1, contour memory read latency in cycles; 0 to 7 are legal.

Ports:
- s_axi_aclk  in  1  sole clock, rising edge.
- s_axi_areset  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE.
- abort  in  1  synchronous cancel of a run.
- num_points  in  CNT_W  contour points per segment; latched at start.
- num_segments  in  SEG_W  segments per run; latched at start.
- trace_ready  in  1  downstream can accept a store.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at normal completion.
- load_center  out  1  one-cycle strobe per segment.
- contour_rden  out  1  contour read enable, high for N cycles per segment.
- load_contour  out  1  one-cycle strobe per segment.
- store_trace  out  1  one-cycle strobe per segment.
- seg_idx  out  SEG_W  current segment index.
- point_idx  out  CNT_W  current contour read address.

Behaviour:
- Reset: state IDLE. busy, done, all strobes, seg_idx and point_idx are 0. Reset takes priority over every other input, including mid-run; no done is issued on reset.
- States: IDLE, LCENTER, READ, RWAIT, LCONTOUR, STORE, DONE.
- IDLE:
  - On start=1, latch N=num_points and S=num_segments, and clear seg_idx and point_idx.
  - Next state is LCENTER, or DONE if S==0.
- LCENTER: load_center=1 for exactly one cycle.
  - Next state is READ if N>0.
  - If N==0, next state is RWAIT when RD_LAT>0, else LCONTOUR.
- READ: contour_rden=1 with point_idx=0..N-1 on consecutive cycles; point_idx increments each cycle.
  - After the cycle with point_idx==N-1, next state is RWAIT if RD_LAT>0, else LCONTOUR.
  - point_idx holds N-1 afterwards until the next LCENTER clears it.
- RWAIT: lasts exactly RD_LAT cycles; no strobes.
- LCONTOUR: load_contour=1 for exactly one cycle, then STORE.
- STORE: store_trace = trace_ready. The state holds while trace_ready=0.
  - On the cycle store_trace=1, if seg_idx==S-1 the next state is DONE.
  - Otherwise seg_idx increments and the next state is LCENTER.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- busy=1 in every state except IDLE and DONE.
- Strobes are state decodes and therefore mutually exclusive. store_trace is the only output combinationally dependent on an input (trace_ready).
- start is ignored outside IDLE. num_points and num_segments changes during a run have no effect.
- abort=1 in any non-IDLE state:
  - next cycle is IDLE with all outputs 0 and no done pulse;
  - any strobe already asserted in the abort cycle is not suppressed.
  - abort in IDLE is a no-op; abort together with start in IDLE wins, so the run does not start.
- Segment count uses a full SEG_W compare, so S=2^SEG_W-1 completes without wrap. point_idx never wraps because N≤2^CNT_W-1.
- Per-segment cycle count with trace_ready=1 is N+RD_LAT+3.

Test Plan:
- Nominal run: RD_LAT=1, N=4, S=2, trace_ready=1, start at cycle 0.
  - load_center at 1 and 9; contour_rden at 2–5 and 10–13 with point_idx 0,1,2,3.
  - load_contour at 7 and 15; store_trace at 8 and 16; seg_idx becomes 1 at cycle 9.
  - done at 17; busy high for cycles 1–16.
- Backpressure: N=2, S=1, trace_ready=0 for 5 cycles after STORE entry. STORE holds 5 cycles, store_trace pulses once on the first ready cycle, done follows next cycle.
- Degenerate counts:
  - S=0 gives done at cycle 1 with no strobes and busy never high.
  - N=0, S=1, RD_LAT=1 gives load_center at 1, load_contour at 3, store_trace at 4, and no contour_rden.
- Abort: assert abort in the third READ cycle of N=8. The next cycle is IDLE with all outputs 0 and no done; a following start runs a clean full sequence.
- Reset mid-run: assert s_axi_areset during STORE. The next cycle has all outputs 0 and state IDLE; start during reset is ignored.
- Ignored inputs: start pulsed while busy, and num_points changed mid-run. The sequence, strobe counts and done timing are identical to the nominal run.
